// File: rtl/llsc_reservation_arbiter.sv
// LL/SC reservation arbiter: round-robin selection of one atomic-relevant op
// per cycle, per-requester reservations with optional lifetime, and a
// registered atomic status returned one cycle after acceptance.
module llsc_reservation_arbiter #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LIFETIME = 1023
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [2*N_REQ-1:0]            req_op,
    input  logic [ADDR_W*N_REQ-1:0]       req_addr,
    output logic                          resp_valid,
    output logic [$clog2(N_REQ)-1:0]      resp_id,
    output logic [1:0]                    resp_atomic,
    output logic [N_REQ-1:0]              resv_valid
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = (LIFETIME > 1) ? $clog2(LIFETIME + 1) : 1;
    localparam int unsigned WA_W  = ADDR_W - 2;

    localparam logic [1:0] OP_LL = 2'b00;
    localparam logic [1:0] OP_SC = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;

    localparam logic [1:0] AT_NOT  = 2'b00;
    localparam logic [1:0] AT_PASS = 2'b01;
    localparam logic [1:0] AT_FAIL = 2'b10;

    logic [ID_W-1:0]  rr_ptr;
    logic [WA_W-1:0]  resv_addr [N_REQ];
    logic [CNT_W-1:0] resv_cnt  [N_REQ];

    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  rr_ptr_nxt;
    logic [1:0]       g_op;
    logic [WA_W-1:0]  g_waddr;
    logic [N_REQ-1:0] match;
    logic [N_REQ-1:0] valid_nxt;
    logic [WA_W-1:0]  addr_nxt  [N_REQ];
    logic [CNT_W-1:0] cnt_nxt   [N_REQ];
    logic [1:0]       atomic_nxt;
    logic             addr_lsb_unused;

    // Round-robin grant starting the search at rr_ptr
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!grant_any && req_valid[ID_W'(idx)]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
        rr_ptr_nxt = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end

    // Select the granted op and its word address
    always_comb begin
        int unsigned gsel;
        gsel    = 32'(grant_id);
        g_op    = req_op[2*gsel +: 2];
        g_waddr = req_addr[ADDR_W*gsel + 2 +: WA_W];
        addr_lsb_unused = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            addr_lsb_unused = addr_lsb_unused ^ (^req_addr[ADDR_W*i +: 2]);
        end
    end

    // Reservation next state: lifetime expiry first, then the granted op
    always_comb begin
        valid_nxt  = resv_valid;
        atomic_nxt = AT_NOT;
        match      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            addr_nxt[i] = resv_addr[i];
            cnt_nxt[i]  = resv_cnt[i];
            match[i]    = resv_valid[i] && (resv_addr[i] == g_waddr);
            if (LIFETIME != 0 && resv_valid[i]) begin
                cnt_nxt[i] = resv_cnt[i] - CNT_W'(1);
                if (resv_cnt[i] == CNT_W'(1)) begin
                    valid_nxt[i] = 1'b0;
                end
            end
        end
        if (grant_any) begin
            case (g_op)
                OP_LL: begin
                    valid_nxt[grant_id] = 1'b1;
                    addr_nxt[grant_id]  = g_waddr;
                    cnt_nxt[grant_id]   = CNT_W'(LIFETIME);
                end
                OP_SC: begin
                    if (match[grant_id]) begin
                        atomic_nxt = AT_PASS;
                        valid_nxt  = valid_nxt & ~match;
                    end else begin
                        atomic_nxt          = AT_FAIL;
                        valid_nxt[grant_id] = 1'b0;
                    end
                end
                OP_SW: begin
                    valid_nxt = valid_nxt & ~match;
                end
                default: ;
            endcase
        end
    end

    // State and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_atomic <= AT_NOT;
            resv_valid  <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                resv_addr[i] <= '0;
                resv_cnt[i]  <= '0;
            end
        end else begin
            if (grant_any) begin
                rr_ptr <= rr_ptr_nxt;
            end
            resp_valid  <= grant_any;
            resp_id     <= grant_id;
            resp_atomic <= atomic_nxt;
            resv_valid  <= valid_nxt;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                resv_addr[i] <= addr_nxt[i];
                resv_cnt[i]  <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_llsc_reservation_arbiter.sv
// Directed bench for llsc_reservation_arbiter (2 requesters, lifetime 4).
module tb_llsc_reservation_arbiter;

    localparam logic [1:0] LL = 2'b00, SC = 2'b01, SW = 2'b10, NP = 2'b11;
    localparam logic [1:0] NOT = 2'b00, PASS = 2'b01, FAIL = 2'b10;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  op0;
        logic [31:0] a0;
        logic [1:0]  op1;
        logic [31:0] a1;
        logic [1:0]  rdy;
        logic        rv;
        logic        id;
        logic [1:0]  at;
        logic [1:0]  resv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [0:0]  resp_id;
    logic [1:0]  resp_atomic;
    logic [1:0]  resv_valid;

    int n_pass  = 0;
    int n_total = 0;
    vec_t vecs[$];

    llsc_reservation_arbiter #(.N_REQ(2), .ADDR_W(32), .LIFETIME(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_atomic(resp_atomic), .resv_valid(resv_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] op0, input logic [31:0] a0,
                                input logic [1:0] op1, input logic [31:0] a1, input logic [1:0] rdy,
                                input logic rv, input logic id, input logic [1:0] at,
                                input logic [1:0] resv);
        vec_t r;
        r.v = v; r.op0 = op0; r.a0 = a0; r.op1 = op1; r.a1 = a1;
        r.rdy = rdy; r.rv = rv; r.id = id; r.at = at; r.resv = resv;
        return r;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] op0, input logic [31:0] a0,
                         input logic [1:0] op1, input logic [31:0] a1);
        req_valid = v;
        req_op    = {op1, op0};
        req_addr  = {a1, a0};
    endtask

    initial begin
        // test 1: LL then SC same address
        vecs.push_back(mk(2'b01, LL, 32'h100, NP, 0, 2'b01, 1, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b01, SC, 32'h100, NP, 0, 2'b01, 1, 0, PASS, 2'b00));
        vecs.push_back(mk(2'b00, NP, 0,       NP, 0, 2'b00, 0, 0, NOT,  2'b00));
        // test 2: SW with byte offset kills both reservations
        vecs.push_back(mk(2'b01, LL, 32'h100, NP, 0,       2'b01, 1, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b10, NP, 0,       LL, 32'h100, 2'b10, 1, 1, NOT,  2'b11));
        vecs.push_back(mk(2'b10, NP, 0,       SW, 32'h102, 2'b10, 1, 1, NOT,  2'b00));
        vecs.push_back(mk(2'b01, SC, 32'h100, NP, 0,       2'b01, 1, 0, FAIL, 2'b00));
        // test 3: passing SC clears the other requester's matching reservation
        vecs.push_back(mk(2'b01, LL, 32'h200, NP, 0,       2'b01, 1, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b10, NP, 0,       LL, 32'h200, 2'b10, 1, 1, NOT,  2'b11));
        vecs.push_back(mk(2'b10, NP, 0,       SC, 32'h200, 2'b10, 1, 1, PASS, 2'b00));
        vecs.push_back(mk(2'b01, SC, 32'h200, NP, 0,       2'b01, 1, 0, FAIL, 2'b00));
        // test 4: realign pointer to 0, then alternating grants
        vecs.push_back(mk(2'b10, NP, 0, NP, 0, 2'b10, 1, 1, NOT, 2'b00));
        vecs.push_back(mk(2'b11, NP, 0, NP, 0, 2'b01, 1, 0, NOT, 2'b00));
        vecs.push_back(mk(2'b11, NP, 0, NP, 0, 2'b10, 1, 1, NOT, 2'b00));
        vecs.push_back(mk(2'b11, NP, 0, NP, 0, 2'b01, 1, 0, NOT, 2'b00));
        vecs.push_back(mk(2'b11, NP, 0, NP, 0, 2'b10, 1, 1, NOT, 2'b00));
        // contending LLs, selective SW, SC with byte offset
        vecs.push_back(mk(2'b11, LL, 32'h300, LL, 32'h304, 2'b01, 1, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b11, LL, 32'h300, LL, 32'h304, 2'b10, 1, 1, NOT,  2'b11));
        vecs.push_back(mk(2'b01, SW, 32'h300, NP, 0,       2'b01, 1, 0, NOT,  2'b10));
        vecs.push_back(mk(2'b10, NP, 0,       SC, 32'h307, 2'b10, 1, 1, PASS, 2'b00));
        // test 5: expiry after four idle cycles
        vecs.push_back(mk(2'b01, LL, 32'h40, NP, 0, 2'b01, 1, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT,  2'b00));
        vecs.push_back(mk(2'b01, SC, 32'h40, NP, 0, 2'b01, 1, 0, FAIL, 2'b00));
        // SC in the final live cycle still passes
        vecs.push_back(mk(2'b01, LL, 32'h40, NP, 0, 2'b01, 1, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT,  2'b01));
        vecs.push_back(mk(2'b01, SC, 32'h40, NP, 0, 2'b01, 1, 0, PASS, 2'b00));
        // LL reload restarts the lifetime
        vecs.push_back(mk(2'b01, LL, 32'h40, NP, 0, 2'b01, 1, 0, NOT, 2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT, 2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT, 2'b01));
        vecs.push_back(mk(2'b01, LL, 32'h40, NP, 0, 2'b01, 1, 0, NOT, 2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT, 2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT, 2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT, 2'b01));
        vecs.push_back(mk(2'b00, NP, 0,      NP, 0, 2'b00, 0, 0, NOT, 2'b00));

        rst_n = 1'b0;
        drive(2'b00, NP, 0, NP, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset resp_valid",  32'(resp_valid),  0);
        check("reset resp_id",     32'(resp_id),     0);
        check("reset resp_atomic", 32'(resp_atomic), 0);
        check("reset resv_valid",  32'(resv_valid),  0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].v, vecs[n].op0, vecs[n].a0, vecs[n].op1, vecs[n].a1);
            #1;
            check($sformatf("row%0d req_ready", n), 32'(req_ready), 32'(vecs[n].rdy));
            @(posedge clk);
            #1;
            check($sformatf("row%0d resp_valid", n), 32'(resp_valid), 32'(vecs[n].rv));
            if (vecs[n].rv) begin
                check($sformatf("row%0d resp_id", n),     32'(resp_id),     32'(vecs[n].id));
                check($sformatf("row%0d resp_atomic", n), 32'(resp_atomic), 32'(vecs[n].at));
            end
            check($sformatf("row%0d resv_valid", n), 32'(resv_valid), 32'(vecs[n].resv));
        end

        // test 6: reset in the cycle after an accept discards everything
        @(negedge clk);
        drive(2'b01, LL, 32'h80, NP, 0);
        @(posedge clk);
        #1;
        check("pre-reset resv_valid", 32'(resv_valid), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst resp_valid", 32'(resp_valid), 0);
        check("rst resv_valid", 32'(resv_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, NP, 0, NP, 0);
        #1;
        check("rst rr_ptr grant", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        check("post-rst resp_id", 32'(resp_id), 0);
        check("post-rst resv_valid", 32'(resv_valid), 0);
        @(negedge clk);
        drive(2'b00, NP, 0, NP, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
